// File: rtl/noc_pkt_mux.sv
// noc_pkt_mux: N-input to 1-output packet-granular flit multiplexer for the
// router output stage. A port wins arbitration with a HEAD flit and keeps the
// output (wormhole lock) until its TAIL flit has been forwarded.
//
// Ports:
//   clk, rst_        rising-edge clock, asynchronous active-low reset
//   idata[N*DW]      input flits, port k at [k*DW +: DW], type in top two bits
//   ivalid[N]        per-port flit valid
//   ivch[N*VCW]      per-port virtual-channel id
//   iready[N]        per-port accept (transfer = ivalid & iready at clk edge)
//   sel[SELW]        requested port when MODE=1, ignored when MODE=0
//   odata/ovch       registered output flit and its VC id
//   ovalid/oready    registered output valid / downstream accept
//   grant[N]         one-hot current owner, 0 while unlocked
//   err              one-cycle pulse after a NONE-typed valid flit was consumed
//   pkt_cnt[CNTW]    saturating count of forwarded TAIL flits
module noc_pkt_mux #(
    parameter int N    = 4,
    parameter int DW   = 66,
    parameter int VCW  = 2,
    parameter int SELW = 4,
    parameter int MODE = 0,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [N*DW-1:0]   idata,
    input  logic [N-1:0]      ivalid,
    input  logic [N*VCW-1:0]  ivch,
    output logic [N-1:0]      iready,
    input  logic [SELW-1:0]   sel,
    output logic [DW-1:0]     odata,
    output logic              ovalid,
    output logic [VCW-1:0]    ovch,
    input  logic              oready,
    output logic [N-1:0]      grant,
    output logic              err,
    output logic [CNTW-1:0]   pkt_cnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b11;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, next_state;
    logic [IW-1:0]   owner, next_owner;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   winner;
    logic            has_winner;
    logic [N-1:0]    is_none, is_head, is_tail;
    logic            slot_free;
    logic            fwd, fwd_tail;
    logic [IW-1:0]   fwd_port;
    logic [DW-1:0]   fwd_data;
    logic [VCW-1:0]  fwd_vch;

    assign slot_free = ~ovalid | oready;

    // Per-port flit type decode, qualified by valid.
    always_comb begin
        is_none = '0;
        is_head = '0;
        is_tail = '0;
        for (int k = 0; k < N; k++) begin
            is_none[k] = ivalid[k] && (idata[k*DW+DW-2 +: 2] == T_NONE);
            is_head[k] = ivalid[k] && (idata[k*DW+DW-2 +: 2] == T_HEAD);
            is_tail[k] = ivalid[k] && (idata[k*DW+DW-2 +: 2] == T_TAIL);
        end
    end

    // Arbitration among HEAD candidates. The round-robin search wraps with an
    // explicit subtract so a non-power-of-two N never visits a phantom port.
    always_comb begin : arbitrate
        int idx;
        has_winner = 1'b0;
        winner     = '0;
        idx        = 0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= N) idx = idx - N;
                if (!has_winner && is_head[IW'(idx)]) begin
                    has_winner = 1'b1;
                    winner     = IW'(idx);
                end
            end
        end else begin
            if (int'(sel) < N && is_head[sel[IW-1:0]]) begin
                has_winner = 1'b1;
                winner     = sel[IW-1:0];
            end
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        next_owner = owner;
        iready     = '0;
        fwd        = 1'b0;
        fwd_tail   = 1'b0;
        fwd_port   = owner;
        unique case (state)
            IDLE: begin
                if (has_winner) begin
                    iready[winner] = slot_free;
                    fwd_port       = winner;
                    fwd            = slot_free;
                    if (slot_free) begin
                        next_state = LOCKED;
                        next_owner = winner;
                    end
                end
            end
            LOCKED: begin
                // HEAD, DATA and TAIL from the owner are all forwarded; only
                // TAIL ends the packet.
                if (ivalid[owner] && !is_none[owner]) begin
                    iready[owner] = slot_free;
                    fwd           = slot_free;
                    fwd_tail      = is_tail[owner];
                    if (slot_free && is_tail[owner]) next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        // NONE flits are always swallowed, independent of lock and back-pressure.
        iready = iready | is_none;
    end

    always_comb begin
        fwd_data = '0;
        fwd_vch  = '0;
        for (int k = 0; k < N; k++) begin
            if (IW'(k) == fwd_port) begin
                fwd_data = idata[k*DW +: DW];
                fwd_vch  = ivch[k*VCW +: VCW];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (state == LOCKED) grant[owner] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            owner <= '0;
        end else begin
            state <= next_state;
            owner <= next_owner;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            odata   <= '0;
            ovch    <= '0;
            ovalid  <= 1'b0;
            err     <= 1'b0;
            pkt_cnt <= '0;
            rr_ptr  <= '0;
        end else begin
            if (fwd) begin
                odata  <= fwd_data;
                ovch   <= fwd_vch;
                ovalid <= 1'b1;
            end else if (oready) begin
                ovalid <= 1'b0;
            end
            err <= |is_none;
            if (fwd && fwd_tail && pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNTW'(1);
            if (MODE == 0 && state == IDLE && fwd)
                rr_ptr <= (winner == IW'(N - 1)) ? '0 : winner + IW'(1);
        end
    end

endmodule

// File: tb/tb_noc_pkt_mux.sv
// Self-checking bench for noc_pkt_mux: a MODE=0 and a MODE=1 instance share
// stimulus; per-port flit sources honour iready, and a scoreboard of expected
// output flits is compared as the active instance's output is accepted.
module tb_noc_pkt_mux;

    localparam int N    = 4;
    localparam int DW   = 66;
    localparam int VCW  = 2;
    localparam int SELW = 4;
    localparam int CNTW = 16;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_DATA = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    typedef struct packed {
        logic [VCW-1:0] vch;
        logic [DW-1:0]  data;
    } flit_t;

    typedef struct {
        int             port;
        int             n_data;
        logic [N-1:0]   exp_grant;
    } pkt_rec_t;

    logic              clk = 1'b0;
    logic              rst_;
    logic [N*DW-1:0]   idata;
    logic [N-1:0]      ivalid;
    logic [N*VCW-1:0]  ivch;
    logic [SELW-1:0]   sel;
    logic              oready;
    logic              use_m1;

    logic [N-1:0]      iready0, iready1, grant0, grant1;
    logic [DW-1:0]     odata0, odata1;
    logic [VCW-1:0]    ovch0, ovch1;
    logic              ovalid0, ovalid1, err0, err1;
    logic [CNTW-1:0]   pkt_cnt0, pkt_cnt1;

    wire [N-1:0]    act_iready = use_m1 ? iready1  : iready0;
    wire [N-1:0]    m_grant    = use_m1 ? grant1   : grant0;
    wire [DW-1:0]   m_odata    = use_m1 ? odata1   : odata0;
    wire [VCW-1:0]  m_ovch     = use_m1 ? ovch1    : ovch0;
    wire            m_ovalid   = use_m1 ? ovalid1  : ovalid0;
    wire            m_err      = use_m1 ? err1     : err0;
    wire [CNTW-1:0] m_pkt_cnt  = use_m1 ? pkt_cnt1 : pkt_cnt0;

    noc_pkt_mux #(.N(N), .DW(DW), .VCW(VCW), .SELW(SELW), .MODE(0), .CNTW(CNTW)) dut0 (
        .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .iready(iready0), .sel(sel), .odata(odata0), .ovalid(ovalid0), .ovch(ovch0),
        .oready(oready), .grant(grant0), .err(err0), .pkt_cnt(pkt_cnt0)
    );

    noc_pkt_mux #(.N(N), .DW(DW), .VCW(VCW), .SELW(SELW), .MODE(1), .CNTW(CNTW)) dut1 (
        .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .iready(iready1), .sel(sel), .odata(odata1), .ovalid(ovalid1), .ovch(ovch1),
        .oready(oready), .grant(grant1), .err(err1), .pkt_cnt(pkt_cnt1)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    int    exp_cnt = 0;
    int    pkt_id = 0;
    flit_t exp_q[$];
    flit_t src [N][32];
    int    src_len [N];
    int    src_ptr [N];
    pkt_rec_t t1 [4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic flit_t mk(input int port, input logic [1:0] typ, input int seq);
        flit_t f;
        f.data = {typ, 32'hC0DE_0000, 32'(port * 256 + seq)};
        f.vch  = VCW'(port + 1);
        return f;
    endfunction

    task automatic add_flit(input int port, input logic [1:0] typ, input int seq, input bit push);
        flit_t f;
        f = mk(port, typ, seq);
        src[port][src_len[port]] = f;
        src_len[port]++;
        if (push) exp_q.push_back(f);
    endtask

    // Packet = HEAD, n_data x DATA, TAIL; expected flits go to the scoreboard.
    task automatic add_pkt(input int port, input int n_data);
        int base;
        base = pkt_id * 16;
        pkt_id++;
        add_flit(port, T_HEAD, base, 1'b1);
        for (int j = 0; j < n_data; j++) add_flit(port, T_DATA, base + 1 + j, 1'b1);
        add_flit(port, T_TAIL, base + 15, 1'b1);
        exp_cnt++;
    endtask

    task automatic clear_port(input int port);
        src_len[port] = 0;
        src_ptr[port] = 0;
    endtask

    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            if (src_ptr[k] < src_len[k]) begin
                ivalid[k]              = 1'b1;
                idata[k*DW +: DW]      = src[k][src_ptr[k]].data;
                ivch[k*VCW +: VCW]     = src[k][src_ptr[k]].vch;
            end else begin
                ivalid[k]              = 1'b0;
                idata[k*DW +: DW]      = '0;
                ivch[k*VCW +: VCW]     = '0;
            end
        end
    endtask

    // One clock: handshake sampled mid-cycle, sources advance after the edge.
    task automatic step();
        logic [N-1:0] xfer;
        @(negedge clk);
        xfer = ivalid & act_iready;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (xfer[k]) src_ptr[k]++;
        refresh();
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_ovalid) && n < 100) begin
            step();
            n++;
        end
        check({name, "_drained"}, 128'(exp_q.size() == 0 && !m_ovalid), 128'(1));
        check({name, "_pkt_cnt"}, 128'(m_pkt_cnt), 128'(exp_cnt));
    endtask

    // Asynchronous assert between edges; outputs must clear without a clock.
    task automatic do_reset(input string name);
        #2;
        rst_ = 1'b0;
        #1;
        check({name, "_rst_ovalid"}, 128'(m_ovalid), 128'(0));
        check({name, "_rst_grant"}, 128'(m_grant), 128'(0));
        check({name, "_rst_pkt_cnt"}, 128'(m_pkt_cnt), 128'(0));
        for (int k = 0; k < N; k++) clear_port(k);
        exp_q.delete();
        exp_cnt = 0;
        refresh();
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        refresh();
        #1;
    endtask

    // Scoreboard: every accepted output flit must match the next expected one.
    always @(negedge clk) begin
        flit_t ef;
        if (rst_ && m_ovalid && oready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_flit: got %0h expected no flit", m_odata);
            end else begin
                ef = exp_q.pop_front();
                check("out_flit", 128'({m_ovch, m_odata}), 128'({ef.vch, ef.data}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_v, run, idx, head_step;
        bit ended;

        t1[0] = '{0, 3, 4'b0001};
        t1[1] = '{1, 3, 4'b0010};
        t1[2] = '{2, 3, 4'b0100};
        t1[3] = '{3, 3, 4'b1000};

        rst_ = 1'b0; ivalid = '0; idata = '0; ivch = '0; sel = '0; oready = 1'b1; use_m1 = 1'b0;
        for (int k = 0; k < N; k++) clear_port(k);

        // Reset state
        @(posedge clk); @(posedge clk); #2;
        check("reset_odata", 128'(odata0), 128'(0));
        check("reset_ovalid", 128'(ovalid0), 128'(0));
        check("reset_grant", 128'(grant0), 128'(0));
        check("reset_err", 128'(err0), 128'(0));
        check("reset_pkt_cnt", 128'(pkt_cnt0), 128'(0));
        check("reset_iready", 128'(iready0), 128'(0));
        @(negedge clk); rst_ = 1'b1;
        @(posedge clk); #1; refresh(); #1;

        // 1: four simultaneous packets served whole in round-robin order
        for (int i = 0; i < 4; i++) add_pkt(t1[i].port, t1[i].n_data);
        refresh(); #1;
        first_v = -1; run = 0; ended = 1'b0; idx = 0; head_step = 1;
        for (int s = 1; s <= 40; s++) begin
            step();
            if (idx < 4 && s == head_step) begin
                check($sformatf("t1_grant%0d", idx), 128'(m_grant), 128'(t1[idx].exp_grant));
                head_step += t1[idx].n_data + 2;
                idx++;
            end
            if (m_ovalid) begin
                if (first_v < 0) first_v = s;
                if (!ended) run++;
            end else if (first_v >= 0) begin
                ended = 1'b1;
            end
        end
        check("t1_first_ovalid", 128'(first_v), 128'(1));
        check("t1_ovalid_run", 128'(run), 128'(20));
        drain("t1");

        // 2: fairness after port 1 finishes
        add_pkt(1, 1);
        refresh(); #1;
        drain("t2a");
        add_pkt(2, 1);
        add_pkt(1, 1);
        refresh(); #1;
        check("t2_iready", 128'(act_iready), 128'(4'b0100));
        step();
        check("t2_grant", 128'(m_grant), 128'(4'b0100));
        drain("t2");

        // 3: back-pressure mid-packet
        add_pkt(0, 4);
        refresh(); #1;
        step(); step();
        add_pkt(3, 1);
        refresh();
        oready = 1'b0;
        #1;
        check("t3_hold_odata0", 128'(m_odata), 128'(exp_q[0].data));
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("t3_hold_odata%0d", c + 1), 128'(m_odata), 128'(exp_q[0].data));
            check($sformatf("t3_hold_ovalid%0d", c + 1), 128'(m_ovalid), 128'(1));
            check($sformatf("t3_iready_zero%0d", c + 1), 128'(act_iready), 128'(0));
        end
        oready = 1'b1;
        drain("t3");

        // 4: MODE=1, port chosen by sel; sel change mid-packet ignored
        use_m1 = 1'b1;
        sel = SELW'(1);
        do_reset("t4");
        add_pkt(1, 2);
        add_pkt(0, 2);
        refresh(); #1;
        check("t4_iready", 128'(act_iready), 128'(4'b0010));
        step();
        check("t4_grant", 128'(m_grant), 128'(4'b0010));
        sel = SELW'(0);
        step();
        check("t4_grant_kept", 128'(m_grant), 128'(4'b0010));
        drain("t4");

        // 5: NONE flit on port 3 while port 0 is locked
        use_m1 = 1'b0;
        do_reset("t5");
        add_pkt(0, 3);
        refresh(); #1;
        step();
        add_flit(3, T_NONE, 99, 1'b0);
        refresh(); #1;
        check("t5_none_iready", 128'(act_iready[3]), 128'(1));
        step();
        check("t5_err_pulse", 128'(m_err), 128'(1));
        step();
        check("t5_err_clear", 128'(m_err), 128'(0));
        drain("t5");
        clear_port(3);
        add_flit(3, T_DATA, 98, 1'b0);
        refresh(); #1;
        check("t5_data_stall0", 128'(act_iready[3]), 128'(0));
        step(); step();
        check("t5_data_stall1", 128'(act_iready[3]), 128'(0));
        check("t5_no_output", 128'(m_ovalid), 128'(0));

        // 6: asynchronous reset mid-packet, then a fresh packet on port 2
        add_pkt(1, 4);
        refresh(); #1;
        step(); step(); step();
        check("t6_locked", 128'(m_grant), 128'(4'b0010));
        do_reset("t6");
        add_pkt(2, 1);
        refresh(); #1;
        step();
        check("t6_grant", 128'(m_grant), 128'(4'b0100));
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noc_pkt_mux.md
Name: noc_pkt_mux

Overview:
- N-input to 1-output packet-granular flit multiplexer for the router output stage. Generalised successor of the 2:1 combinational port mux.
- Adds the following over the 2:1 mux:
  - parametrised port count and width;
  - wormhole locking from HEAD to TAIL;
  - round-robin or externally selected arbitration;
  - valid/ready back-pressure;
  - a registered output;
  - a forwarded-packet counter.

Parameters:
N, 4, number of input ports (2..16)
DW, 66, flit width; bits [DW-1:DW-2] are the type field, rest payload
VCW, 2, virtual-channel id width
SELW, 4, width of sel (must be >= clog2(N))
MODE, 0, 0 = round-robin arbitration; 1 = fixed port chosen by sel
CNTW, 16, width of packet counter

Ports:
clk  in  1  clock, rising edge
rst_  in  1  asynchronous active-low reset
idata  in  N*DW  flattened input flits, port k at [k*DW +: DW]
ivalid  in  N  per-port flit valid
ivch  in  N*VCW  flattened per-port VC id
iready  out  N  per-port accept; a flit transfers on port k when ivalid[k] & iready[k] at clk edge
sel  in  SELW  requested port (MODE=1 only; ignored when MODE=0)
odata  out  DW  registered output flit
ovalid  out  1  registered output valid
ovch  out  VCW  registered output VC id
oready  in  1  downstream accept
grant  out  N  one-hot current owner (0 when unlocked)
err  out  1  one-cycle pulse: TYPE_NONE flit consumed with ivalid=1
pkt_cnt  out  CNTW  count of TAIL flits forwarded, saturating

Behaviour:
- Type encoding: 2'b00 NONE, 2'b01 HEAD, 2'b10 DATA, 2'b11 TAIL. Minimum packet is HEAD+TAIL.
- Reset (async assert, sync deassert assumed upstream) sets:
  - odata=0, ovalid=0, ovch=0, grant=0, err=0, pkt_cnt=0;
  - rr pointer=0;
  - state IDLE.
- Output slot free: slot_free = ~ovalid | oready.
- Output register:
  - loads odata/ovch from the transferring port and sets ovalid=1 on any forwarded transfer;
  - clears ovalid when oready=1 and nothing transfers;
  - holds while ovalid=1 and oready=0.
- States: IDLE and LOCKED(k).
- IDLE:
  - Candidates are ports with ivalid=1 and type HEAD.
    - MODE=0: winner is the first candidate searching upward from the rr pointer, modulo N.
    - MODE=1: the winner is port sel, only if sel<N and that port is a candidate; otherwise no winner.
  - iready[winner]=slot_free. All other iready=0, except NONE-typed valid flits (see below).
  - On winner transfer, go to LOCKED(winner) and set grant to one-hot winner.
  - MODE=0: rr pointer = (winner+1) mod N.
  - No transfer leaves the state unchanged.
- LOCKED(k):
  - iready[k]=slot_free; all others 0, except NONE handling below.
  - sel changes are ignored.
  - DATA and HEAD on port k are forwarded. A HEAD inside a packet is forwarded unchanged; it carries no special meaning.
  - A TAIL transfer on port k does all of the following at that edge:
    - returns the state to IDLE;
    - sets grant=0;
    - increments pkt_cnt, saturating at all-ones.
  - The next arbitration happens in the following cycle. The head flit transfers at the edge after the tail: no bubble when slot_free.
- DATA or TAIL on a non-owner port, or on any port while IDLE: iready=0. The flit is held, never dropped.
- NONE-typed flit with ivalid=1 on any port k that is not blocked:
  - iready[k]=1; the flit is consumed and not forwarded;
  - err pulses in the next cycle.
  - Does not affect state or the rr pointer.
  - Takes priority over arbitration only for that port; other ports proceed.
- Latency: input transfer at edge t, flit on odata with ovalid=1 from t+1. Throughput is 1 flit/cycle when oready is held high.
- Back-pressure: ovalid=1 and oready=0 gives iready=0 for all non-NONE flits. odata is stable until accepted.
- Reset mid-packet drops the lock and any held output flit. No partial state survives.
- N not a power of two: the rr wrap uses explicit mod N; there are no phantom ports.

Test Plan:
1. MODE=0, N=4. Ports 0..3 each send HEAD, DATA×3, TAIL simultaneously, with oready=1.
   - Packets are output whole in order 0,1,2,3, with no interleaving.
   - 20 consecutive ovalid cycles starting 1 cycle after the first head.
   - pkt_cnt=4.
2. Fairness. After port 1 finishes a packet, ports 1 and 2 both present HEAD.
   - Port 2 wins; grant=4'b0100; port 1 is served next.
3. Back-pressure. oready=0 for 3 cycles mid-packet.
   - odata is held unchanged and all iready=0.
   - On release, the sequence resumes with no lost or duplicated flits.
4. MODE=1, sel=1. Ports 0 and 1 both hold HEAD.
   - Only port 1 is granted.
   - sel changed to 0 mid-packet: port 1 continues until TAIL; port 0 is granted after.
5. Port 3 presents a NONE flit while port 0 is locked.
   - iready[3]=1 and err=1 one cycle later.
   - odata is unaffected.
   - A DATA flit on port 3 while unlocked stays stalled (iready[3]=0).
6. Assert rst_=0 asynchronously mid-packet (between clock edges).
   - ovalid, grant and pkt_cnt go to 0 immediately.
   - After deassertion, a new HEAD on port 2 is granted normally.
